// File: rtl/ifetch_unit.sv
`default_nettype none
// ifetch_unit: owns the PC, issues in-order word fetches and buffers returned words
// with their PCs for decode; a redirect flushes the buffer and drops stale responses.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        Redirect_valid_i,
  input  logic [31:0] Redirect_pc_i,
  output logic        Imem_req_o,
  output logic [31:0] Imem_addr_o,
  input  logic        Imem_gnt_i,
  input  logic        Imem_rvalid_i,
  input  logic [31:0] Imem_rdata_i,
  output logic        Valid_o,
  input  logic        Ready_i,
  output logic [31:0] Instr_o,
  output logic [31:0] Pc_o
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0]    used, pend, drop_cnt;

  logic             req_int, grant, pop, resp_keep, resp_drop;
  logic [CW:0]      occupancy, drop_sum, drop_redirect;
  logic             unused_low_bits;

  assign unused_low_bits = ^Redirect_pc_i[1:0];

  assign occupancy = {1'b0, used} + {1'b0, drop_cnt};
  assign req_int   = ~Redirect_valid_i & (occupancy < DEPTH_C);
  assign grant     = req_int & Imem_gnt_i;
  assign Valid_o   = filled_q[head_ptr] & ~Redirect_valid_i;
  assign pop       = Valid_o & Ready_i;
  assign resp_drop = Imem_rvalid_i & (drop_cnt != '0);
  assign resp_keep = Imem_rvalid_i & (drop_cnt == '0) & (pend != '0);

  // On redirect every allocated-but-unfilled entry becomes a stale response to drop,
  // minus the one (if any) arriving in the redirect cycle itself.
  assign drop_sum      = {1'b0, drop_cnt} + {1'b0, pend};
  assign drop_redirect = (Imem_rvalid_i && drop_sum != '0) ? drop_sum - (CW+1)'(1) : drop_sum;

  // Reset only gates the port, so rst_n_i never enters a flop data path.
  assign Imem_req_o  = req_int & rst_n_i;
  assign Imem_addr_o = fetch_pc;
  assign Instr_o     = Valid_o ? data_q[head_ptr] : NOP;
  assign Pc_o        = Valid_o ? pc_q[head_ptr]   : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc  <= RESET_PC;
      filled_q  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pend      <= '0;
      drop_cnt  <= '0;
    end else if (Redirect_valid_i) begin
      fetch_pc  <= {Redirect_pc_i[31:2], 2'b00};
      filled_q  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pend      <= '0;
      drop_cnt  <= drop_redirect[CW-1:0];
    end else begin
      if (grant) begin
        fetch_pc  <= fetch_pc + 32'd4;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (resp_keep) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (pop) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
      case ({grant, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
      case ({grant, resp_keep})
        2'b10:   pend <= pend + CW'(1);
        2'b01:   pend <= pend - CW'(1);
        default: pend <= pend;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by filled_q.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      pc_q[alloc_ptr] <= fetch_pc;
    end
    if (resp_keep && !Redirect_valid_i) begin
      data_q[fill_ptr] <= Imem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, buffers returned words with their PCs, and hands them to `decode` through a valid/ready interface. Taken branches and jumps from execute arrive as a redirect that flushes everything in flight and restarts fetch at the new target.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `DEPTH`, 4, buffer entries and maximum outstanding fetches; power of two, ≥2
- `clk_i`  in  1  clock, all state on rising edge
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `Redirect_valid_i`  in  1  taken branch/jump from execute, single-cycle pulse
- `Redirect_pc_i`  in  32  new fetch target; bits [1:0] forced to 0
- `Imem_req_o`  out  1  fetch request
- `Imem_addr_o`  out  32  fetch address (word aligned)
- `Imem_gnt_i`  in  1  request accepted this cycle
- `Imem_rvalid_i`  in  1  response valid; in order, ≥1 cycle after its grant
- `Imem_rdata_i`  in  32  response word
- `Valid_o`  out  1  `Instr_o`/`Pc_o` valid to decode
- `Ready_i`  in  1  decode accepts this cycle
- `Instr_o`  out  32  instruction word to decode
- `Pc_o`  out  32  PC of `Instr_o`

## Operation
- State: `fetch_pc`, circular buffer of DEPTH entries {pc, data, filled}, pointers `alloc_ptr`/`fill_ptr`/`head_ptr`, `used` count (0..DEPTH), `drop_cnt` (0..DEPTH).
- Request: `Imem_req_o = ~Redirect_valid_i & (used + drop_cnt < DEPTH)`; `Imem_addr_o = fetch_pc`. Uses registered counts only, with no combinational path from `Ready_i`.
- Grant (`req & gnt`): allocate the entry at `alloc_ptr` with pc=`fetch_pc`, filled=0; `fetch_pc += 4` (wraps mod 2^32); `used++`.
- Response: if `drop_cnt != 0`, discard the word and decrement `drop_cnt`. Otherwise write data to the entry at `fill_ptr`, set filled=1, advance `fill_ptr`.
- Output: `Valid_o = head.filled & ~Redirect_valid_i`; `Instr_o = head.data` when `Valid_o`, else 32'h0000_0013 (NOP); `Pc_o = head.pc` when `Valid_o`, else 0.
- Pop (`Valid_o & Ready_i`): advance `head_ptr`, `used--`. Grant and pop in the same cycle leave `used` unchanged.
- Redirect (highest priority):
  - `fetch_pc <= {Redirect_pc_i[31:2],2'b00}`.
  - Clear all entries; reset all pointers and `used` to 0.
  - `drop_cnt <= drop_cnt + (allocated-but-unfilled entries) − (1 if a response arrives this cycle)`. Any response in the redirect cycle belongs to the old stream and is discarded.
  - No request, grant or pop takes effect that cycle.
- A `gnt` while `Imem_req_o=0` is illegal and ignored.
- A request left ungranted may be withdrawn only by a redirect. Otherwise `Imem_req_o`/`Imem_addr_o` hold until granted.

## Timing
- Reset (async assert): `fetch_pc=RESET_PC`, buffer empty, `drop_cnt=0`.
- Output values during reset: `Imem_req_o=0`, `Imem_addr_o=RESET_PC`, `Valid_o=0`, `Instr_o=32'h0000_0013`, `Pc_o=0`.
- First request is raised in the first cycle after `rst_n_i` deasserts.
- Reset mid-operation: everything returns to reset values. Responses to pre-reset grants are the memory's responsibility; the memory is reset alongside.
- Latency: grant at cycle t, rvalid at earliest t+1, `Valid_o` at t+2.
- Redirect at cycle r: the first request to the new target is at r+1, and its data is at `Valid_o` ≥ r+3.
- Throughput: with DEPTH=4, a 1-cycle-latency memory and `Ready_i` held high, sustains 1 instruction/cycle.
- Full (`used + drop_cnt = DEPTH`): `Imem_req_o=0` until a pop or drop frees space. Space freed in cycle t allows a request in cycle t+1.
- Empty or head unfilled: `Valid_o=0`. `Ready_i` is ignored.

## Test plan
- Reset release with `RESET_PC`=0x100, memory returning `0x00000093+addr`, grant every cycle, 1-cycle latency, `Ready_i=1`:
  - requests to 0x100, 0x104, 0x108…
  - from cycle 2, `Valid_o`=1 every cycle with `Pc_o` 0x100, 0x104… and the matching `Instr_o`.
- `Ready_i=0` for 10 cycles: exactly 4 grants occur, then `Imem_req_o`=0. After `Ready_i=1`, PCs emerge in order with none lost or duplicated.
- Redirect to 0x2003 with 3 fetches outstanding:
  - `Pc_o` never shows an old-stream PC after the redirect.
  - the 3 old responses are dropped.
  - the first new `Pc_o`=0x2000.
- Redirect coincident with `Imem_rvalid_i` and with `Valid_o & Ready_i`:
  - the response is dropped and the head is not counted as consumed.
  - `Valid_o`=0 in that cycle.
- Memory with random 1–5 cycle latency and random grant stalls, plus random redirects:
  - the scoreboard of PC→word matches for every handshake.
  - `used + drop_cnt` never exceeds 4.
- Assert `rst_n_i` mid-burst asynchronously (between edges): all outputs immediately take their reset values, and the restart fetches `RESET_PC`.
